// File: rtl/clk_div_monitor.sv
// Receive-side qualifier for a divided clock: synchronizes clk_in into the clk domain, detects
// its edges, measures period and high time, and reports lock / loss status.

module clk_div_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             period_update,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned      MatchW     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [MatchW-1:0] LockVal   = MatchW'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StMeasure, StLocked, StLost} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   rise_evt, fall_evt;
  logic                   rise_tick_q, fall_tick_q;
  logic [CNT_W-1:0]       elapsed_q, elapsed_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   armed_q, armed_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   update_q, update_d;
  logic                   locked_q, locked_d;
  logic                   lost_q, lost_d;
  logic [MatchW-1:0]      match_q, match_d, match_next;
  logic                   same_period, timeout, capture, go_lost;

  // Edge events are seen one cycle before the registered ticks; all state updates on that edge.
  assign rise_evt = sync_q[SYNC_STAGES-1] & ~delay_q;
  assign fall_evt = ~sync_q[SYNC_STAGES-1] & delay_q;
  assign timeout  = (elapsed_q == TimeoutVal) && !rise_evt;

  assign same_period = valid_q && (elapsed_q == period_q);

  always_comb begin
    if (!same_period) begin
      match_next = MatchW'(1);
    end else if (match_q == LockVal) begin
      match_next = match_q;
    end else begin
      match_next = match_q + 1'b1;
    end
  end

  always_comb begin
    if (rise_evt) begin
      elapsed_d = CNT_W'(1);
    end else if (elapsed_q == CntMax) begin
      elapsed_d = elapsed_q;
    end else begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    locked_d  = locked_q;
    lost_d    = lost_q;
    match_d   = match_q;
    armed_d   = armed_q;
    pending_d = pending_q;
    capture   = 1'b0;
    go_lost   = 1'b0;

    // A fall only counts as a high phase once a rise has been seen since reset or loss.
    if (rise_evt) begin
      armed_d = 1'b1;
    end else if (fall_evt && armed_q) begin
      pending_d = elapsed_q;
    end

    case (state_q)
      StIdle: begin
        if (rise_evt) begin
          state_d = StMeasure;
        end else if (timeout) begin
          go_lost = 1'b1;
        end
      end
      StMeasure: begin
        if (rise_evt) begin
          capture = 1'b1;
          match_d = match_next;
          if (match_next == LockVal) begin
            state_d  = StLocked;
            locked_d = 1'b1;
          end
        end else if (timeout) begin
          go_lost = 1'b1;
        end
      end
      StLocked: begin
        if (rise_evt) begin
          capture = 1'b1;
          if (same_period) begin
            match_d = match_next;
          end else begin
            match_d  = MatchW'(1);
            locked_d = 1'b0;
            state_d  = StMeasure;
          end
        end else if (timeout) begin
          go_lost = 1'b1;
        end
      end
      StLost: begin
        // The interval since the last rise is stale, so this rise only restarts measurement.
        if (rise_evt) begin
          state_d = StMeasure;
          lost_d  = 1'b0;
          match_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      period_d = elapsed_q;
      high_d   = pending_q;
      valid_d  = 1'b1;
      update_d = 1'b1;
    end

    if (go_lost) begin
      state_d  = StLost;
      lost_d   = 1'b1;
      locked_d = 1'b0;
      valid_d  = 1'b0;
      match_d  = '0;
      armed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      delay_q     <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
      elapsed_q   <= '0;
      pending_q   <= '0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      match_q     <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], clk_in};
      delay_q     <= sync_q[SYNC_STAGES-1];
      rise_tick_q <= rise_evt;
      fall_tick_q <= fall_evt;
      elapsed_q   <= elapsed_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
      match_q     <= match_d;
    end
  end

  assign rise_tick     = rise_tick_q;
  assign fall_tick     = fall_tick_q;
  assign period        = period_q;
  assign high_time     = high_q;
  assign period_valid  = valid_q;
  assign period_update = update_q;
  assign locked        = locked_q;
  assign lost          = lost_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock at two ratios, edge latency, timeout, relock and
// asynchronous reset, with hand-computed expectations.

module tb_clk_div_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_in;
  logic        rise_tick, fall_tick;
  logic [15:0] period, high_time;
  logic        period_valid, period_update, locked, lost;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t_prev      = 0;
  int half        = 2;
  int half_next   = 2;
  int ph          = 0;
  bit run         = 1'b0;

  clk_div_monitor #(
    .CNT_W      (16),
    .TIMEOUT    (64),
    .LOCK_COUNT (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .period_update(period_update),
    .locked       (locked),
    .lost         (lost)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk cycle; outputs are sampled 1 time unit after the edge, then clk_in is advanced.
  // A new half-period takes effect at the next rising toggle of clk_in.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (run) begin
      if (ph == half - 1) begin
        clk_in = ~clk_in;
        ph     = 0;
        if (clk_in) half = half_next;
      end else begin
        ph++;
      end
    end
  endtask

  task automatic wait_rise(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (rise_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic rise_chk(input string tag, input int gap, input int per, input int hi,
                          input bit upd, input bit val, input bit lck, input bit lst);
    int n;
    int d;
    wait_rise(16, n);
    d      = (n < 0) ? -1 : cyc - t_prev;
    t_prev = cyc;
    if (gap > 0) check({tag, "_gap"}, 32'(d), 32'(gap));
    else         check({tag, "_seen"}, 32'(n > 0), 32'd1);
    if (per > 0) check({tag, "_period"}, 32'(period), 32'(per));
    if (hi > 0)  check({tag, "_high"}, 32'(high_time), 32'(hi));
    check({tag, "_update"}, 32'(period_update), 32'(upd));
    check({tag, "_valid"}, 32'(period_valid), 32'(val));
    check({tag, "_locked"}, 32'(locked), 32'(lck));
    check({tag, "_lost"}, 32'(lost), 32'(lst));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"}, 32'(rise_tick), 32'd0);
    check({tag, "_fall"}, 32'(fall_tick), 32'd0);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_high"}, 32'(high_time), 32'd0);
    check({tag, "_valid"}, 32'(period_valid), 32'd0);
    check({tag, "_update"}, 32'(period_update), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_lost"}, 32'(lost), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    clk_in = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    step();
    check("idle_lost", 32'(lost), 32'd0);

    // Single rise first sampled at edge k: rise_tick high only in cycle k+2.
    clk_in    = 1'b1;
    ph        = 0;
    half      = 2;
    half_next = 2;
    run       = 1'b1;
    step();
    check("lat_k", 32'(rise_tick), 32'd0);
    step();
    check("lat_k1", 32'(rise_tick), 32'd0);
    step();
    t_prev = cyc;
    check("lat_k2", 32'(rise_tick), 32'd1);
    check("first_rise_update", 32'(period_update), 32'd0);
    check("first_rise_valid", 32'(period_valid), 32'd0);
    step();
    check("rise_width", 32'(rise_tick), 32'd0);
    check("fall_early", 32'(fall_tick), 32'd0);
    step();
    check("fall_at_2", 32'(fall_tick), 32'd1);

    // Divide-by-4 stream: lock on the fifth rise.
    for (int r = 2; r <= 5; r++)
      rise_chk($sformatf("div4_r%0d", r), 4, 4, 2, 1'b1, 1'b1, r == 5, 1'b0);

    // Hold clk_in low: loss exactly TIMEOUT cycles after the last rise_tick.
    run    = 1'b0;
    clk_in = 1'b0;
    repeat (63) step();
    check("pre_timeout_lost", 32'(lost), 32'd0);
    check("pre_timeout_locked", 32'(locked), 32'd1);
    step();
    check("timeout_lost", 32'(lost), 32'd1);
    check("timeout_locked", 32'(locked), 32'd0);
    check("timeout_valid", 32'(period_valid), 32'd0);
    check("timeout_period", 32'(period), 32'd4);

    // Resume at half-period 3: first rise only clears lost.
    clk_in    = 1'b1;
    ph        = 0;
    half      = 3;
    half_next = 3;
    run       = 1'b1;
    rise_chk("resume_r1", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 2; r <= 5; r++)
      rise_chk($sformatf("div6_r%0d", r), 6, 6, 3, 1'b1, 1'b1, r == 5, 1'b0);

    // Move to period 4, then back to 6 while locked: lock drops on the first new capture.
    half_next = 2;
    rise_chk("to4_r1", 6, 6, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int r = 2; r <= 5; r++)
      rise_chk($sformatf("to4_r%0d", r), 4, 4, 2, 1'b1, 1'b1, r == 5, 1'b0);
    half_next = 3;
    rise_chk("to6_r1", 4, 4, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int r = 2; r <= 5; r++)
      rise_chk($sformatf("to6_r%0d", r), 6, 6, 3, 1'b1, 1'b1, r == 5, 1'b0);

    // Asynchronous reset while clk_in is high, between clk edges.
    for (int i = 0; i < 8 && clk_in !== 1'b1; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    step();
    reset = 1'b0;
    rise_chk("post_reset_r1", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rise_chk("post_reset_r2", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    rise_chk("post_reset_r3", 6, 6, 3, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Receive-side checker for a divided clock produced by the team's clock dividers. It takes the divided clock in as plain data and synchronizes it into the system `clk` domain. It detects its edges, measures period and high time in `clk` cycles, and reports lock, loss and measurement status. It sits next to any divider whose output must be qualified before downstream logic uses it as a tick or enable.

Parameters:
CNT_W, 16, width of period/high-time counters and outputs.
TIMEOUT, 1000, `clk` cycles without a rising edge before loss is declared; must be < 2^CNT_W-1.
LOCK_COUNT, 4, consecutive identical captured periods required to declare lock; must be ≥ 2.
SYNC_STAGES, 2, synchronizer flop count on clk_in; must be ≥ 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
clk_in  input  1  divided clock under observation, asynchronous to clk.
rise_tick  output  1  one-cycle pulse per detected rising edge of clk_in.
fall_tick  output  1  one-cycle pulse per detected falling edge of clk_in.
period  output  CNT_W  last captured rise-to-rise distance in clk cycles.
high_time  output  CNT_W  last captured rise-to-fall distance in clk cycles.
period_valid  output  1  period/high_time hold a valid measurement.
period_update  output  1  one-cycle pulse when period is (re)captured.
locked  output  1  LOCK_COUNT consecutive identical periods seen.
lost  output  1  no rising edge within TIMEOUT cycles.

Behaviour:
- One clock domain, `clk`.
- `reset` is asynchronous and active-high.
  - While asserted, all outputs are 0, synchronizer and counters are 0, and the FSM is IDLE.
  - Deassertion takes effect on the next clk edge.
- Synchronizer: SYNC_STAGES flops, then one delay flop.
  - If clk_in is first sampled high at edge k, rise_tick is high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1.
  - fall_tick follows the same timing.
- All outputs are registered.
- Elapsed counter:
  - Loaded to 1 on the cycle rise_tick asserts; otherwise +1 per cycle.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Capture rule: rise_tick in cycles t0 and t1 gives period = t1-t0.
  - fall_tick at cycle tf after rise t0 gives a pending high time of tf-t0.
  - high_time is updated together with period, using the pending value from the preceding high phase.
- FSM states: IDLE, MEASURE, LOCKED, LOST.
  - IDLE:
    - rise → MEASURE. No capture, because there is no previous edge.
    - Elapsed count reaching TIMEOUT → LOST.
  - MEASURE, on rise:
    - Capture period/high_time, set period_valid=1, pulse period_update.
    - If the new period equals the previous captured period, increment match_cnt; otherwise set match_cnt=1.
    - match_cnt reaching LOCK_COUNT → LOCKED, locked=1 in the same cycle as that period_update.
  - MEASURE, on timeout → LOST.
  - LOCKED:
    - rise with equal period → capture, stay LOCKED.
    - rise with different period → capture, match_cnt=1, locked=0 in the same cycle, go to MEASURE.
    - Timeout → LOST.
  - LOST:
    - lost=1, locked=0, period_valid=0; period/high_time keep their stale values.
    - rise → MEASURE with lost=0 and no capture, because the interval is stale.
- Timeout: the elapsed count equals TIMEOUT with no rise_tick in that cycle.
  - If rise_tick and timeout coincide, the rise wins.
  - TIMEOUT counts from the last rise, or from reset deassertion in IDLE.
- clk_in stuck high: a fall is never detected and the timeout still fires.
- A fall without a preceding rise (after reset or after LOST) is ignored for high time.
- Divider ratio: clk_in with half-period H clk cycles gives period = 2H and high_time = H.

Test Plan:
1. Reset, then clk_in toggles every 2 clk (num_div=2 divider) → rise_tick every 4 cycles; period=4, high_time=2; period_valid after the 2nd rise; locked=1 at the 5th rise; lost=0.
2. Single clk_in rise sampled at edge k, SYNC_STAGES=2 → rise_tick high exactly during cycle k+2..k+3, one cycle wide.
3. After lock, hold clk_in low, TIMEOUT=64 → lost=1 and locked=0, period_valid=0 exactly 64 cycles after the last rise_tick; period stays 4.
4. From LOST, resume with half-period 3 → first rise clears lost with no period_update; second rise gives period=6, high_time=3; locked at the 5th rise.
5. While locked at period 4, switch to half-period 3 → locked drops in the cycle period=6 is captured; relocks after 4 identical captures.
6. Assert reset mid-high-phase, asynchronous to clk → all outputs 0 immediately; after release with clk_in running, the first rise produces no capture.
